// File: rtl/svm_modality_scheduler_if.sv
// rtl/svm_modality_scheduler_if.sv - sample, feature, result and upstream-result bundle for the modality scheduler
interface svm_modality_scheduler_if #(
  parameter int NBITS     = 16,
  parameter int F_WIDTH   = 16,
  parameter int ID_WIDTH  = 8,
  parameter int LAT_WIDTH = 16
) ();
  logic                     s_valid;
  logic                     s_ready;
  logic [NBITS*F_WIDTH-1:0] s_v_features;
  logic [NBITS*F_WIDTH-1:0] s_a_features;

  logic                     fin_valid;
  logic                     fin_ready;
  logic [NBITS*F_WIDTH-1:0] in_features;

  logic                     valence;
  logic                     arousal;
  logic                     dout_valid;
  logic                     dout_ready;

  logic                     r_valid;
  logic                     r_ready;
  logic                     r_valence;
  logic                     r_arousal;
  logic [ID_WIDTH-1:0]      r_id;
  logic [LAT_WIDTH-1:0]     r_latency;
  logic                     r_timeout;

  // Scheduler side
  modport slave (
    input  s_valid, s_v_features, s_a_features,
    input  fin_ready,
    input  valence, arousal, dout_valid,
    input  r_ready,
    output s_ready, fin_valid, in_features, dout_ready,
    output r_valid, r_valence, r_arousal, r_id, r_latency, r_timeout
  );

  // Environment side: feature front end, SVM core and result consumer
  modport master (
    output s_valid, s_v_features, s_a_features,
    output fin_ready,
    output valence, arousal, dout_valid,
    output r_ready,
    input  s_ready, fin_valid, in_features, dout_ready,
    input  r_valid, r_valence, r_arousal, r_id, r_latency, r_timeout
  );
endinterface

// File: rtl/svm_modality_scheduler.sv
// rtl/svm_modality_scheduler.sv - serialises valence/arousal vectors into the SVM core and returns tagged labels
module svm_modality_scheduler #(
  parameter int NBITS     = 16,
  parameter int F_WIDTH   = 16,
  parameter int ID_WIDTH  = 8,
  parameter int LAT_WIDTH = 16,
  parameter int TIMEOUT   = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  svm_modality_scheduler_if.slave bus
);
  localparam int VW = NBITS * F_WIDTH;
  localparam logic [LAT_WIDTH-1:0] LAT_MAX = '1;
  localparam logic [LAT_WIDTH-1:0] TO_LAST = LAT_WIDTH'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEND_V,
    SEND_A,
    WAIT_OUT,
    EMIT
  } state_e;

  state_e               state_q, state_d;
  logic                 s_ready_q, s_ready_d;
  logic                 fin_valid_q, fin_valid_d;
  logic                 dout_ready_q, dout_ready_d;
  logic                 r_valid_q, r_valid_d;
  logic [VW-1:0]        in_feat_q, in_feat_d;
  logic [VW-1:0]        a_vec_q, a_vec_d;
  logic                 r_valence_q, r_valence_d;
  logic                 r_arousal_q, r_arousal_d;
  logic [ID_WIDTH-1:0]  r_id_q, r_id_d;
  logic [LAT_WIDTH-1:0] r_lat_q, r_lat_d;
  logic                 r_timeout_q, r_timeout_d;
  logic [ID_WIDTH-1:0]  id_q, id_d;
  logic [LAT_WIDTH-1:0] lat_q, lat_d;

  logic                 s_hs, fin_hs, dout_hs, r_hs;
  logic [LAT_WIDTH-1:0] lat_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      s_ready_q    <= 1'b1;
      fin_valid_q  <= 1'b0;
      dout_ready_q <= 1'b0;
      r_valid_q    <= 1'b0;
      in_feat_q    <= '0;
      a_vec_q      <= '0;
      r_valence_q  <= 1'b0;
      r_arousal_q  <= 1'b0;
      r_id_q       <= '0;
      r_lat_q      <= '0;
      r_timeout_q  <= 1'b0;
      id_q         <= '0;
      lat_q        <= '0;
    end else begin
      state_q      <= state_d;
      s_ready_q    <= s_ready_d;
      fin_valid_q  <= fin_valid_d;
      dout_ready_q <= dout_ready_d;
      r_valid_q    <= r_valid_d;
      in_feat_q    <= in_feat_d;
      a_vec_q      <= a_vec_d;
      r_valence_q  <= r_valence_d;
      r_arousal_q  <= r_arousal_d;
      r_id_q       <= r_id_d;
      r_lat_q      <= r_lat_d;
      r_timeout_q  <= r_timeout_d;
      id_q         <= id_d;
      lat_q        <= lat_d;
    end
  end

  assign s_hs    = bus.s_valid & s_ready_q;
  assign fin_hs  = fin_valid_q & bus.fin_ready;
  assign dout_hs = dout_ready_q & bus.dout_valid;
  assign r_hs    = r_valid_q & bus.r_ready;
  assign lat_inc = (lat_q == LAT_MAX) ? lat_q : lat_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    s_ready_d    = s_ready_q;
    fin_valid_d  = fin_valid_q;
    dout_ready_d = dout_ready_q;
    r_valid_d    = r_valid_q;
    in_feat_d    = in_feat_q;
    a_vec_d      = a_vec_q;
    r_valence_d  = r_valence_q;
    r_arousal_d  = r_arousal_q;
    r_id_d       = r_id_q;
    r_lat_d      = r_lat_q;
    r_timeout_d  = r_timeout_q;
    id_d         = id_q;
    lat_d        = lat_q;

    case (state_q)
      IDLE: begin
        if (s_hs) begin
          in_feat_d   = bus.s_v_features;
          a_vec_d     = bus.s_a_features;
          fin_valid_d = 1'b1;
          s_ready_d   = 1'b0;
          state_d     = SEND_V;
        end
      end
      SEND_V: begin
        if (fin_hs) begin
          lat_d     = '0;
          in_feat_d = a_vec_q;
          state_d   = SEND_A;
        end
      end
      SEND_A: begin
        lat_d = lat_inc;
        if (fin_hs) begin
          fin_valid_d  = 1'b0;
          dout_ready_d = 1'b1;
          state_d      = WAIT_OUT;
        end
      end
      WAIT_OUT: begin
        lat_d = lat_inc;
        // A real answer on the timeout cycle takes priority over the abort
        if (dout_hs) begin
          r_valence_d  = bus.valence;
          r_arousal_d  = bus.arousal;
          r_lat_d      = lat_q;
          r_id_d       = id_q;
          r_timeout_d  = 1'b0;
          r_valid_d    = 1'b1;
          dout_ready_d = 1'b0;
          state_d      = EMIT;
        end else if (lat_q >= TO_LAST) begin
          r_valence_d  = 1'b0;
          r_arousal_d  = 1'b0;
          r_lat_d      = TO_LAST;
          r_id_d       = id_q;
          r_timeout_d  = 1'b1;
          r_valid_d    = 1'b1;
          dout_ready_d = 1'b0;
          state_d      = EMIT;
        end
      end
      EMIT: begin
        if (r_hs) begin
          r_valid_d = 1'b0;
          id_d      = id_q + 1'b1;
          s_ready_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d      = IDLE;
        s_ready_d    = 1'b1;
        fin_valid_d  = 1'b0;
        dout_ready_d = 1'b0;
        r_valid_d    = 1'b0;
      end
    endcase
  end

  assign bus.s_ready     = s_ready_q;
  assign bus.fin_valid   = fin_valid_q;
  assign bus.in_features = in_feat_q;
  assign bus.dout_ready  = dout_ready_q;
  assign bus.r_valid     = r_valid_q;
  assign bus.r_valence   = r_valence_q;
  assign bus.r_arousal   = r_arousal_q;
  assign bus.r_id        = r_id_q;
  assign bus.r_latency   = r_lat_q;
  assign bus.r_timeout   = r_timeout_q;
endmodule

// File: tb/tb_svm_modality_scheduler.sv
// tb/tb_svm_modality_scheduler.sv - directed self-checking bench for svm_modality_scheduler
module tb_svm_modality_scheduler;
  localparam int NBITS     = 16;
  localparam int F_WIDTH   = 4;
  localparam int ID_WIDTH  = 2;
  localparam int LAT_WIDTH = 16;
  localparam int TIMEOUT   = 16;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   fin_hs_cnt = 0;

  always #5 clk = ~clk;

  svm_modality_scheduler_if #(
    .NBITS(NBITS), .F_WIDTH(F_WIDTH), .ID_WIDTH(ID_WIDTH), .LAT_WIDTH(LAT_WIDTH)
  ) bus ();

  svm_modality_scheduler #(
    .NBITS(NBITS), .F_WIDTH(F_WIDTH), .ID_WIDTH(ID_WIDTH),
    .LAT_WIDTH(LAT_WIDTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk) begin
    if (!rst && bus.fin_valid && bus.fin_ready) fin_hs_cnt <= fin_hs_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 64'(bus.s_ready), 64'd1);
    check({tag, "_fin_valid"}, 64'(bus.fin_valid), 64'd0);
    check({tag, "_dout_ready"}, 64'(bus.dout_ready), 64'd0);
    check({tag, "_r_valid"}, 64'(bus.r_valid), 64'd0);
    check({tag, "_in_features"}, 64'(bus.in_features), 64'd0);
    check({tag, "_r_id"}, 64'(bus.r_id), 64'd0);
    check({tag, "_r_latency"}, 64'(bus.r_latency), 64'd0);
    check({tag, "_r_timeout"}, 64'(bus.r_timeout), 64'd0);
    check({tag, "_r_labels"}, 64'({bus.r_valence, bus.r_arousal}), 64'd0);
  endtask

  task automatic do_sample(input logic [63:0] v, input logic [63:0] a,
                           input int sv_stall, input int sa_stall, input int dly, input int hold,
                           input logic lv, input logic la, input logic [1:0] eid,
                           input logic [15:0] elat, input logic eto,
                           input bit no_ans, input bit abort);
    int base;
    int n;
    base = fin_hs_cnt;
    check("s_ready_idle", 64'(bus.s_ready), 64'd1);
    bus.s_v_features = v;
    bus.s_a_features = a;
    bus.s_valid = 1'b1;
    tick();
    bus.s_valid = 1'b0;
    bus.s_v_features = '0;
    bus.s_a_features = '0;
    check("send_v_valid", 64'(bus.fin_valid), 64'd1);
    check("send_v_data", bus.in_features, v);
    check("s_ready_busy", 64'(bus.s_ready), 64'd0);

    bus.fin_ready = 1'b0;
    repeat (sv_stall) begin
      tick();
      check("v_stall_valid", 64'(bus.fin_valid), 64'd1);
      check("v_stall_data", bus.in_features, v);
      check("v_stall_s_ready", 64'(bus.s_ready), 64'd0);
    end
    bus.fin_ready = 1'b1;
    tick();
    check("send_a_valid", 64'(bus.fin_valid), 64'd1);
    check("send_a_data", bus.in_features, a);

    bus.fin_ready = 1'b0;
    repeat (sa_stall) begin
      tick();
      check("a_stall_valid", 64'(bus.fin_valid), 64'd1);
      check("a_stall_data", bus.in_features, a);
    end
    bus.fin_ready = 1'b1;
    tick();
    check("wait_fin_valid", 64'(bus.fin_valid), 64'd0);
    check("wait_dout_ready", 64'(bus.dout_ready), 64'd1);
    check("fin_hs_count", 64'(fin_hs_cnt - base), 64'd2);

    if (abort) begin
      #2 rst = 1'b1;
      #1;
      check_reset_outputs("abort");
      tick();
      tick();
      check("abort_no_result", 64'(bus.r_valid), 64'd0);
      rst = 1'b0;
      tick();
      check("abort_idle", 64'(bus.s_ready), 64'd1);
      return;
    end

    if (no_ans) begin
      n = 0;
      while (!bus.r_valid && n < 40) begin
        tick();
        n++;
      end
      check("timeout_cycles", 64'(n), 64'd15);
    end else begin
      repeat (dly) tick();
      bus.dout_valid = 1'b1;
      bus.valence = lv;
      bus.arousal = la;
      tick();
      bus.dout_valid = 1'b0;
      bus.valence = 1'b0;
      bus.arousal = 1'b0;
    end

    check("emit_r_valid", 64'(bus.r_valid), 64'd1);
    check("emit_dout_ready", 64'(bus.dout_ready), 64'd0);
    check("emit_s_ready", 64'(bus.s_ready), 64'd0);
    check("emit_r_valence", 64'(bus.r_valence), 64'(lv));
    check("emit_r_arousal", 64'(bus.r_arousal), 64'(la));
    check("emit_r_id", 64'(bus.r_id), 64'(eid));
    check("emit_r_latency", 64'(bus.r_latency), 64'(elat));
    check("emit_r_timeout", 64'(bus.r_timeout), 64'(eto));

    bus.r_ready = 1'b0;
    repeat (hold) begin
      tick();
      check("hold_r_valid", 64'(bus.r_valid), 64'd1);
      check("hold_r_id", 64'(bus.r_id), 64'(eid));
      check("hold_r_latency", 64'(bus.r_latency), 64'(elat));
      check("hold_labels", 64'({bus.r_valence, bus.r_arousal, bus.r_timeout}), 64'({lv, la, eto}));
      check("hold_s_ready", 64'(bus.s_ready), 64'd0);
    end
    bus.r_ready = 1'b1;
    tick();
    check("r_valid_clear", 64'(bus.r_valid), 64'd0);
    check("s_ready_back", 64'(bus.s_ready), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    logic [63:0] ones, negs, mix1, mix2;
    ones = {4{16'h0001}};
    negs = {4{16'hFFFF}};
    mix1 = 64'h1234_8000_7FFF_00A5;
    mix2 = 64'hFEDC_0001_5A5A_C3C3;

    rst = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_v_features = '0;
    bus.s_a_features = '0;
    bus.fin_ready = 1'b1;
    bus.valence = 1'b0;
    bus.arousal = 1'b0;
    bus.dout_valid = 1'b0;
    bus.r_ready = 1'b1;
    tick();
    tick();
    check_reset_outputs("reset");
    rst = 1'b0;
    tick();

    // single sample, core answers 5 cycles after the SEND_A handshake
    do_sample(ones, negs, 0, 0, 5, 0, 1'b1, 1'b0, 2'd0, 16'd6, 1'b0, 1'b0, 1'b0);
    // core backpressure: 3 stalls in SEND_V, 2 in SEND_A
    do_sample(mix1, mix2, 3, 2, 2, 0, 1'b0, 1'b1, 2'd1, 16'd5, 1'b0, 1'b0, 1'b0);
    // upstream backpressure for 10 cycles
    do_sample(mix2, mix1, 0, 0, 0, 10, 1'b1, 1'b1, 2'd2, 16'd1, 1'b0, 1'b0, 1'b0);
    // timeout: core never answers
    do_sample(negs, ones, 0, 0, 0, 0, 1'b0, 1'b0, 2'd3, 16'd15, 1'b1, 1'b1, 1'b0);

    bus.dout_valid = 1'b1;
    bus.valence = 1'b1;
    bus.arousal = 1'b1;
    repeat (3) begin
      tick();
      check("stale_r_valid", 64'(bus.r_valid), 64'd0);
      check("stale_dout_ready", 64'(bus.dout_ready), 64'd0);
    end
    bus.dout_valid = 1'b0;
    bus.valence = 1'b0;
    bus.arousal = 1'b0;

    // answer on the exact timeout cycle wins; ID wraps to 0
    do_sample(ones, mix1, 0, 0, 14, 0, 1'b1, 1'b0, 2'd0, 16'd15, 1'b0, 1'b0, 1'b0);
    // reset during WAIT_OUT
    do_sample(mix1, ones, 0, 0, 0, 0, 1'b0, 1'b0, 2'd1, 16'd0, 1'b0, 1'b0, 1'b1);
    // ID restarts at 0 after reset
    do_sample(negs, mix2, 0, 0, 3, 0, 1'b0, 1'b1, 2'd0, 16'd4, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
